// File: rtl/rv_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_hazard_ctrl_pkg
// Shared definitions for the uRV pipeline sequencing controller:
//   - HZ_ST_* : state encodings, exported on state_o for debug. MC_WAIT keeps
//               its code in every build so state_o decodes identically whether
//               or not URV_HAZARD_MULDIV_EN is defined.
//   - hz_ctrl_t : the six stall/kill strobes bundled for the output logic.
// -----------------------------------------------------------------------------
package rv_hazard_ctrl_pkg;

    localparam logic [2:0] HZ_ST_RUN       = 3'd0;
    localparam logic [2:0] HZ_ST_LOAD_WAIT = 3'd1;
    localparam logic [2:0] HZ_ST_FLUSH     = 3'd2;
    localparam logic [2:0] HZ_ST_MEM_WAIT  = 3'd3;
    localparam logic [2:0] HZ_ST_MC_WAIT   = 3'd4;

    typedef struct packed {
        logic f_stall;
        logic f_kill;
        logic d_stall;
        logic d_kill;
        logic x_stall;
        logic x_kill;
    } hz_ctrl_t;

endpackage

// File: rtl/rv_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// rv_hazard_ctrl_if
// Event/strobe bundle between the uRV pipeline stages and rv_hazard_ctrl.
//   Events (pipeline -> controller):
//     x_valid_i, x_load_hazard_i, x_branch_taken_i, dm_load_pending_i,
//     dm_ready_i, and x_mc_start_i / x_mc_done_i when URV_HAZARD_MULDIV_EN
//     is defined.
//   Strobes (controller -> pipeline):
//     f_stall_o, f_kill_o, d_stall_o, d_kill_o, x_stall_o, x_kill_o,
//     state_o[2:0] (debug).
//   Modports: master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface rv_hazard_ctrl_if;

    logic       x_valid_i;
    logic       x_load_hazard_i;
    logic       x_branch_taken_i;
    logic       dm_load_pending_i;
    logic       dm_ready_i;
`ifdef URV_HAZARD_MULDIV_EN
    logic       x_mc_start_i;
    logic       x_mc_done_i;
`endif
    logic       f_stall_o;
    logic       f_kill_o;
    logic       d_stall_o;
    logic       d_kill_o;
    logic       x_stall_o;
    logic       x_kill_o;
    logic [2:0] state_o;

    modport master (
        output x_valid_i, x_load_hazard_i, x_branch_taken_i,
               dm_load_pending_i, dm_ready_i,
`ifdef URV_HAZARD_MULDIV_EN
        output x_mc_start_i, x_mc_done_i,
`endif
        input  f_stall_o, f_kill_o, d_stall_o, d_kill_o,
               x_stall_o, x_kill_o, state_o
    );

    modport slave (
        input  x_valid_i, x_load_hazard_i, x_branch_taken_i,
               dm_load_pending_i, dm_ready_i,
`ifdef URV_HAZARD_MULDIV_EN
        input  x_mc_start_i, x_mc_done_i,
`endif
        output f_stall_o, f_kill_o, d_stall_o, d_kill_o,
               x_stall_o, x_kill_o, state_o
    );

endinterface

// File: rtl/rv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// rv_hazard_ctrl
// Pipeline sequencing controller for the uRV core. Turns hazard/resolution
// events into Mealy stall and kill strobes for fetch, decode and execute.
// Handles load-use interlock, wrong-path flush after taken branches/jumps,
// data-memory wait and, with URV_HAZARD_MULDIV_EN defined, multicycle ALU ops.
//
// Parameters:
//   FLUSH_CYCLES : decode-kill cycles after a taken branch, including the
//                  resolve cycle (legal 1..7).
// Ports:
//   clk_i : core clock
//   rst_i : asynchronous, active-high reset
//   hz    : rv_hazard_ctrl_if.slave (events in, strobes and state_o out)
// Configuration macro: URV_HAZARD_MULDIV_EN (adds x_mc_start_i/x_mc_done_i
//   and makes MC_WAIT reachable).
// -----------------------------------------------------------------------------
module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv_hazard_ctrl_if.slave  hz
);

    localparam logic [2:0] L_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_next_state;
    logic [2:0] w_next_cnt;
    hz_ctrl_t   w_ctrl;

    // NOTE: every signal written here gets a default first so no path through
    // the case/if tree leaves it unassigned (which would infer a latch).
    always_comb begin
        w_ctrl       = '0;
        w_next_state = r_state;
        w_next_cnt   = r_flush_cnt;

        case (r_state)
            HZ_ST_RUN: begin
                // Priority: branch > mem-wait > multicycle > load hazard.
                if (hz.x_branch_taken_i && hz.x_valid_i) begin
                    // Kills only: stalling a stage that is being killed would
                    // preserve a wrong-path instruction.
                    w_ctrl.f_kill = 1'b1;
                    w_ctrl.d_kill = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = HZ_ST_FLUSH;
                        w_next_cnt   = L_FLUSH_INIT;
                    end
                end else if (hz.x_valid_i && !hz.dm_ready_i) begin
                    // dm_ready_i is held high by data memory when no access
                    // is outstanding, so low with a valid op means a memory op.
                    w_ctrl.f_stall = 1'b1;
                    w_ctrl.d_stall = 1'b1;
                    w_ctrl.x_stall = 1'b1;
                    w_next_state   = HZ_ST_MEM_WAIT;
`ifdef URV_HAZARD_MULDIV_EN
                end else if (hz.x_mc_start_i) begin
                    // Start and done together is a single-cycle op: no stall.
                    if (!hz.x_mc_done_i) begin
                        w_ctrl.f_stall = 1'b1;
                        w_ctrl.d_stall = 1'b1;
                        w_ctrl.x_stall = 1'b1;
                        w_next_state   = HZ_ST_MC_WAIT;
                    end
`endif
                end else if (hz.x_load_hazard_i && hz.x_valid_i) begin
                    w_ctrl.f_stall = 1'b1;
                    w_ctrl.d_stall = 1'b1;
                    w_ctrl.x_kill  = 1'b1;
                    if (hz.dm_load_pending_i) begin
                        w_next_state = HZ_ST_LOAD_WAIT;
                    end
                end
            end

            HZ_ST_LOAD_WAIT: begin
                if (hz.dm_load_pending_i) begin
                    w_ctrl.f_stall = 1'b1;
                    w_ctrl.d_stall = 1'b1;
                    w_ctrl.x_kill  = 1'b1;
                end else begin
                    w_next_state = HZ_ST_RUN;
                end
            end

            HZ_ST_FLUSH: begin
                // Hazard and branch events here come from wrong-path
                // instructions and are deliberately not looked at.
                w_ctrl.d_kill = 1'b1;
                w_next_cnt    = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) begin
                    w_next_state = HZ_ST_RUN;
                end
            end

            HZ_ST_MEM_WAIT: begin
                if (!hz.dm_ready_i) begin
                    w_ctrl.f_stall = 1'b1;
                    w_ctrl.d_stall = 1'b1;
                    w_ctrl.x_stall = 1'b1;
                end else begin
                    w_next_state = HZ_ST_RUN;
                end
            end

`ifdef URV_HAZARD_MULDIV_EN
            HZ_ST_MC_WAIT: begin
                if (!hz.x_mc_done_i) begin
                    w_ctrl.f_stall = 1'b1;
                    w_ctrl.d_stall = 1'b1;
                    w_ctrl.x_stall = 1'b1;
                end else begin
                    w_next_state = HZ_ST_RUN;
                end
            end
`endif

            default: begin
                w_next_state = HZ_ST_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= HZ_ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_cnt;
        end
    end

    // Strobes are Mealy on the inputs, so they are also forced low while reset
    // is held; otherwise a live event could leak a strobe through reset.
    assign hz.f_stall_o = w_ctrl.f_stall & ~rst_i;
    assign hz.f_kill_o  = w_ctrl.f_kill  & ~rst_i;
    assign hz.d_stall_o = w_ctrl.d_stall & ~rst_i;
    assign hz.d_kill_o  = w_ctrl.d_kill  & ~rst_i;
    assign hz.x_stall_o = w_ctrl.x_stall & ~rst_i;
    assign hz.x_kill_o  = w_ctrl.x_kill  & ~rst_i;
    assign hz.state_o   = r_state;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_hazard_ctrl
// Self-checking bench for rv_hazard_ctrl (FLUSH_CYCLES = 3). A behavioural
// model tracks "remaining decode-kill cycles" and pending-wait flags and is
// compared against the DUT on every falling edge; directed sequences add
// hand-computed strobe counts and state values.
// -----------------------------------------------------------------------------
module tb_rv_hazard_ctrl;

    localparam int FC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_hazard_ctrl_if hz_if ();

    rv_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz_if)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {f_stall, f_kill, d_stall, d_kill, x_stall, x_kill, state[2:0]}
    function automatic logic [8:0] obs();
        return {hz_if.f_stall_o, hz_if.f_kill_o, hz_if.d_stall_o, hz_if.d_kill_o,
                hz_if.x_stall_o, hz_if.x_kill_o, hz_if.state_o};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_kill_left = 0;   // further cycles decode must still be killed
    bit m_load_wait = 0;
    bit m_mem_wait  = 0;
    bit m_mc_wait   = 0;

    always @(negedge clk) begin : compare
        logic fs, fk, ds, dk, xs, xk;
        logic [2:0] es;
        if (chk_en) begin
            {fs, fk, ds, dk, xs, xk} = '0;
            es = 3'd0;
            if (rst) begin
                m_kill_left = 0;
                m_load_wait = 0;
                m_mem_wait  = 0;
                m_mc_wait   = 0;
            end else if (m_kill_left > 0) begin
                es = 3'd2;
                dk = 1'b1;
                m_kill_left--;
            end else if (m_load_wait) begin
                es = 3'd1;
                if (hz_if.dm_load_pending_i) {fs, ds, xk} = 3'b111;
                else m_load_wait = 0;
            end else if (m_mem_wait) begin
                es = 3'd3;
                if (!hz_if.dm_ready_i) {fs, ds, xs} = 3'b111;
                else m_mem_wait = 0;
            end else if (m_mc_wait) begin
                es = 3'd4;
`ifdef URV_HAZARD_MULDIV_EN
                if (!hz_if.x_mc_done_i) {fs, ds, xs} = 3'b111;
                else m_mc_wait = 0;
`endif
            end else begin
                if (hz_if.x_branch_taken_i && hz_if.x_valid_i) begin
                    {fk, dk} = 2'b11;
                    m_kill_left = FC - 1;
                end else if (hz_if.x_valid_i && !hz_if.dm_ready_i) begin
                    {fs, ds, xs} = 3'b111;
                    m_mem_wait = 1;
`ifdef URV_HAZARD_MULDIV_EN
                end else if (hz_if.x_mc_start_i) begin
                    if (!hz_if.x_mc_done_i) begin
                        {fs, ds, xs} = 3'b111;
                        m_mc_wait = 1;
                    end
`endif
                end else if (hz_if.x_load_hazard_i && hz_if.x_valid_i) begin
                    {fs, ds, xk} = 3'b111;
                    m_load_wait = hz_if.dm_load_pending_i;
                end
            end
            check("cycle_model", 16'(obs()), 16'({fs, fk, ds, dk, xs, xk, es}));
        end
    end

    // ---------------- directed stimulus ----------------
    int c_fs, c_fk, c_ds, c_dk, c_xs, c_xk;
    logic [2:0] last_state;

    task automatic clr();
        {c_fs, c_fk, c_ds, c_dk, c_xs, c_xk} = '0;
    endtask

    // Observe one cycle at the falling edge, then advance to just past the
    // next rising edge where the following vector is applied.
    task automatic tick();
        @(negedge clk);
        c_fs += int'(hz_if.f_stall_o);
        c_fk += int'(hz_if.f_kill_o);
        c_ds += int'(hz_if.d_stall_o);
        c_dk += int'(hz_if.d_kill_o);
        c_xs += int'(hz_if.x_stall_o);
        c_xk += int'(hz_if.x_kill_o);
        last_state = hz_if.state_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_if.x_valid_i         = 1'b1;
        hz_if.x_load_hazard_i   = 1'b0;
        hz_if.x_branch_taken_i  = 1'b0;
        hz_if.dm_load_pending_i = 1'b0;
        hz_if.dm_ready_i        = 1'b1;
`ifdef URV_HAZARD_MULDIV_EN
        hz_if.x_mc_start_i      = 1'b0;
        hz_if.x_mc_done_i       = 1'b0;
`endif
    endtask

    // {valid, load_hazard, branch_taken, load_pending, dm_ready}
    logic [4:0] vec_tbl [22] = '{
        5'b10001, 5'b11011, 5'b11011, 5'b10010, 5'b10000, 5'b10001,
        5'b11101, 5'b11001, 5'b10001, 5'b10001, 5'b10100, 5'b01001,
        5'b00101, 5'b11110, 5'b10011, 5'b10001, 5'b00000, 5'b10000,
        5'b10101, 5'b11011, 5'b10001, 5'b10001
    };

    initial begin
        idle();
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset state.
        clr();
        tick();
        tick();
        check("reset_strobes", 16'(c_fs + c_fk + c_ds + c_dk + c_xs + c_xk), 16'd0);
        check("reset_state", 16'(last_state), 16'd0);
        rst = 1'b0;

        // Taken branch, hazard pulse inside FLUSH must be ignored.
        clr();
        hz_if.x_branch_taken_i = 1'b1;
        tick();
        hz_if.x_branch_taken_i = 1'b0;
        hz_if.x_load_hazard_i  = 1'b1;
        hz_if.dm_load_pending_i = 1'b1;
        tick();
        check("br_state_flush", 16'(last_state), 16'd2);
        idle();
        tick();
        tick();
        tick();
        check("br_f_kill_cycles", 16'(c_fk), 16'd1);
        check("br_d_kill_cycles", 16'(c_dk), 16'd3);
        check("br_no_stall", 16'(c_fs + c_ds + c_xs + c_xk), 16'd0);
        check("br_back_to_run", 16'(last_state), 16'd0);

        // Load hazard with load pending for 4 cycles after the hazard.
        clr();
        hz_if.x_load_hazard_i   = 1'b1;
        hz_if.dm_load_pending_i = 1'b1;
        tick();
        hz_if.x_load_hazard_i = 1'b0;
        repeat (4) tick();
        check("lw_state", 16'(last_state), 16'd1);
        hz_if.dm_load_pending_i = 1'b0;
        tick();
        tick();
        check("lw_f_stall_cycles", 16'(c_fs), 16'd5);
        check("lw_x_kill_cycles", 16'(c_xk), 16'd5);
        check("lw_x_stall_zero", 16'(c_xs), 16'd0);

        // One-cycle hazard without a pending load: exactly one bubble.
        clr();
        hz_if.x_load_hazard_i = 1'b1;
        tick();
        check("bubble_state_run", 16'(last_state), 16'd0);
        idle();
        tick();
        check("bubble_x_kill", 16'(c_xk), 16'd1);
        check("bubble_stalls", 16'(c_fs + c_ds), 16'd2);

        // Memory op with dm_ready low for 3 cycles.
        clr();
        hz_if.dm_ready_i = 1'b0;
        repeat (3) tick();
        check("mw_state", 16'(last_state), 16'd3);
        hz_if.dm_ready_i = 1'b1;
        tick();
        tick();
        check("mw_stall_cycles", 16'({c_fs[7:0], c_xs[7:0]}), 16'h0303);
        check("mw_no_kill", 16'(c_fk + c_dk + c_xk), 16'd0);

        // dm_ready high in the entry cycle: no stall, no MEM_WAIT.
        clr();
        tick();
        check("mw_ready_entry", 16'({c_fs + c_ds + c_xs, 32'(last_state)}), 16'd0);

        // Branch together with dm_ready low: kills win, FSM enters FLUSH.
        clr();
        hz_if.x_branch_taken_i = 1'b1;
        hz_if.dm_ready_i       = 1'b0;
        tick();
        check("brmw_kills", 16'(c_fk + c_dk), 16'd2);
        check("brmw_no_stall", 16'(c_fs + c_ds + c_xs), 16'd0);
        idle();
        tick();
        check("brmw_state_flush", 16'(last_state), 16'd2);
        tick();
        tick();

        // Reset asserted during FLUSH clears everything immediately.
        hz_if.x_branch_taken_i = 1'b1;
        tick();
        hz_if.x_branch_taken_i = 1'b0;
        check("pre_rst_d_kill", 16'(hz_if.d_kill_o), 16'd1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 16'(obs()), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        clr();
        hz_if.x_branch_taken_i = 1'b1;
        tick();
        hz_if.x_branch_taken_i = 1'b0;
        repeat (3) tick();
        check("post_rst_d_kill", 16'(c_dk), 16'd3);
        check("post_rst_f_kill", 16'(c_fk), 16'd1);

`ifdef URV_HAZARD_MULDIV_EN
        // Multicycle op: done 32 cycles after start.
        clr();
        hz_if.x_mc_start_i = 1'b1;
        tick();
        hz_if.x_mc_start_i = 1'b0;
        repeat (31) tick();
        check("mc_state", 16'(last_state), 16'd4);
        hz_if.x_mc_done_i = 1'b1;
        tick();
        hz_if.x_mc_done_i = 1'b0;
        tick();
        check("mc_stall_cycles", 16'(c_fs), 16'd32);
        check("mc_x_stall_cycles", 16'(c_xs), 16'd32);
        // Start and done in the same cycle: no stall.
        clr();
        hz_if.x_mc_start_i = 1'b1;
        hz_if.x_mc_done_i  = 1'b1;
        tick();
        idle();
        tick();
        check("mc_same_cycle", 16'(c_fs + c_ds + c_xs), 16'd0);
        check("mc_same_cycle_state", 16'(last_state), 16'd0);
`endif

        // Directed vector table; the per-cycle model does the checking.
        for (int i = 0; i < 22; i++) begin
            {hz_if.x_valid_i, hz_if.x_load_hazard_i, hz_if.x_branch_taken_i,
             hz_if.dm_load_pending_i, hz_if.dm_ready_i} = vec_tbl[i];
            tick();
        end
        idle();
        repeat (6) tick();
        check("final_state_run", 16'(last_state), 16'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_hazard_ctrl.md
# rv_hazard_ctrl

Pipeline sequencing controller for the uRV core. It takes hazard and resolution events from the decode/execute stages and generates the stall and kill strobes that drive fetch, decode (`d_stall_i`/`d_kill_i`) and execute. It owns a small state machine covering four cases: load-use interlock, wrong-path flush after taken branches/jumps, data-memory wait, and (optionally) multicycle ALU ops. It sits beside the pipeline registers and contains no datapath.

## Interface
- `FLUSH_CYCLES`, default 2: cycles during which decode is killed after a taken branch, inclusive of the resolve cycle; legal range 1..7.
- `clk_i` input 1: single core clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `x_valid_i` input 1: execute stage holds a valid instruction.
- `x_load_hazard_i` input 1: instruction entering execute depends on the load currently in flight.
- `x_branch_taken_i` input 1: execute resolved a taken branch, JAL or JALR this cycle.
- `dm_load_pending_i` input 1: a load issued to data memory has not yet returned data.
- `dm_ready_i` input 1: data memory accepts/completes the current access.
- `x_mc_start_i` input 1: execute starts a multicycle op (present only with the macro).
- `x_mc_done_i` input 1: multicycle op result valid this cycle (present only with the macro).
- `f_stall_o` output 1: hold the fetch PC and IR.
- `f_kill_o` output 1: discard the fetched instruction.
- `d_stall_o` output 1: hold the decode registers.
- `d_kill_o` output 1: decode emits an invalid instruction.
- `x_stall_o` output 1: hold the execute stage.
- `x_kill_o` output 1: inject a bubble into execute.
- `state_o` output 3: current state, for debug.

## Operation
- States: RUN, LOAD_WAIT, FLUSH, MEM_WAIT, MC_WAIT.
- **RUN**
  - All outputs 0 unless an event below applies.
  - Event priority: branch > mem-wait > multicycle > load hazard.
- **Branch**: `x_branch_taken_i && x_valid_i` in RUN.
  - Resolve cycle: `f_kill_o = d_kill_o = 1` combinationally.
  - If `FLUSH_CYCLES > 1`, go to FLUSH and load the counter with `FLUSH_CYCLES-1`. Otherwise stay in RUN.
- **FLUSH**
  - `d_kill_o = 1` while in this state; the counter decrements each cycle.
  - Go to RUN in the cycle after the counter reaches 1.
  - `x_load_hazard_i` and `x_branch_taken_i` are ignored, because they come from killed instructions.
- **Mem-wait**: `x_valid_i && !dm_ready_i` for a memory op in execute.
  - `f_stall_o = d_stall_o = x_stall_o = 1`; go to MEM_WAIT.
  - In MEM_WAIT the stalls equal `!dm_ready_i`; go to RUN on the cycle `dm_ready_i = 1`.
- **Load hazard**: `x_load_hazard_i && x_valid_i` in RUN.
  - `f_stall_o = d_stall_o = x_kill_o = 1`.
  - If `dm_load_pending_i`, go to LOAD_WAIT.
- **LOAD_WAIT**
  - Hold `f_stall_o = d_stall_o = x_kill_o = 1` while `dm_load_pending_i`.
  - Outputs drop and the FSM returns to RUN in the first cycle `dm_load_pending_i = 0`.
- **MC_WAIT**: entered on `x_mc_start_i`.
  - `f_stall_o = d_stall_o = x_stall_o = !x_mc_done_i`.
  - Go to RUN on `x_mc_done_i`.
- **Invariants**
  - `*_stall_o` and `*_kill_o` of the same stage are never both 1; kill wins.
  - `x_kill_o` and `x_stall_o` are never both 1.

## Timing
- Reset: state RUN, counter 0, every output 0, `state_o = 0`. Asserting `rst_i` at any point, including mid-FLUSH or mid-wait, clears state asynchronously.
- Outputs are Mealy: state plus the same-cycle inputs, with zero latency from event to strobe.
- Taken branch in cycle N with `FLUSH_CYCLES = 2`: `d_kill_o` is high in N and N+1; RUN in N+2.
- A one-cycle load hazard with `dm_load_pending_i = 0` gives exactly one bubble and no state change.
- `dm_ready_i` rising in the entry cycle: MEM_WAIT is never entered and no stall is produced.
- `x_mc_start_i` and `x_mc_done_i` both high in the same cycle: no stall, stay in RUN.

## Configuration
- Macro: `URV_HAZARD_MULDIV_EN`.
- Defined: the `x_mc_start_i`/`x_mc_done_i` ports and the MC_WAIT state exist.
- Undefined: those ports are absent and MC_WAIT is unreachable. The encoding still reserves MC_WAIT so that `state_o` values stay identical across builds.

## Structure
- State encodings (`HZ_ST_RUN = 0`, `LOAD_WAIT = 1`, `FLUSH = 2`, `MEM_WAIT = 3`, `MC_WAIT = 4`) go as defines in `rv_defs.v`.
- `OPC_LOAD`/`OPC_STORE` are reused from there.
- Single module with no sub-module. The flush counter is a 3-bit register inside it.

## Test plan
- Reset asserted in the FLUSH cycle after a branch: all outputs go to 0 immediately, `state_o = 0`, and the next branch behaves normally.
- `x_branch_taken_i` pulse with `FLUSH_CYCLES = 3`: `f_kill_o` for 1 cycle, `d_kill_o` for 3 cycles; a hazard pulse in FLUSH is ignored.
- Load hazard with `dm_load_pending_i` held for 4 cycles: `f_stall_o`, `d_stall_o` and `x_kill_o` high for 5 cycles, `x_stall_o` stays 0.
- `dm_ready_i` low for 3 cycles with a memory op in execute: all three stalls high for 3 cycles, then drop with `dm_ready_i`.
- Branch and `!dm_ready_i` asserted together: kills win, no stall asserted, FSM goes to FLUSH.
- With the macro defined, `x_mc_start_i` then `x_mc_done_i` 32 cycles later: stalls high for 32 cycles. With the macro undefined, the build succeeds and no stall is ever asserted.
